// File: rtl/sram_like_arbiter.sv
// Arbitrates one shared SRAM-like port between the instruction-fetch and data masters.
// One transaction in flight; data has priority, with a starvation guard for fetches.
module sram_like_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_wen,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wen,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,

    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] W_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] W_CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_owner;
    logic             w_owner_next;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_next;
    logic             w_own_req;
    logic             w_inst_wins;

    assign w_own_req   = r_owner ? data_req : inst_req;
    assign w_inst_wins = inst_req && (!data_req || (r_starve_cnt == W_STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_starve_next = r_starve_cnt;
        case (r_state)
            IDLE: begin
                if (inst_req || data_req) begin
                    w_state_next = ARB_ADDR;
                    if (w_inst_wins) begin
                        w_owner_next  = 1'b0;
                        w_starve_next = '0;
                    end else begin
                        // Data grant: count it only while a fetch is left waiting.
                        w_owner_next = 1'b1;
                        if (!inst_req) begin
                            w_starve_next = '0;
                        end else if (r_starve_cnt != W_STARVE_MAX) begin
                            w_starve_next = r_starve_cnt + W_CNT_ONE;
                        end
                    end
                end
            end
            ARB_ADDR: begin
                if (mem_addr_ok) begin
                    w_state_next = ARB_DATA;
                end else if (!w_own_req) begin
                    w_state_next = IDLE;
                end
            end
            ARB_DATA: begin
                if (mem_data_ok) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Every output is held at zero while rst is low, even before the state register settles.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wen      = 4'd0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_rdata   = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_rdata   = 32'd0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        owner        = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            owner = r_owner;
            busy  = (r_state != IDLE);
            if (r_owner) begin
                mem_wr     = data_wr;
                mem_wen    = data_wen;
                mem_size   = data_size;
                mem_addr   = data_addr;
                mem_wdata  = data_wdata;
                data_rdata = mem_rdata;
            end else begin
                mem_wr     = inst_wr;
                mem_wen    = inst_wen;
                mem_size   = inst_size;
                mem_addr   = inst_addr;
                mem_wdata  = inst_wdata;
                inst_rdata = mem_rdata;
            end
            if (r_state == ARB_ADDR) begin
                mem_req      = w_own_req;
                inst_addr_ok = !r_owner && mem_addr_ok;
                data_addr_ok = r_owner && mem_addr_ok;
            end
            if (r_state == ARB_DATA) begin
                inst_data_ok = !r_owner && mem_data_ok;
                data_data_ok = r_owner && mem_data_ok;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, single fetch, contention order,
// cancel, write passthrough and reset in the middle of a transaction.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [3:0]  inst_wen;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        owner, busy;

    int n_vec = 0;
    int n_err = 0;

    sram_like_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_wen(inst_wen), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        inst_req = 0; inst_wr = 0; inst_wen = 0; inst_size = 2'd2;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_wen = 0; data_size = 2'd2;
        data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 0;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            n_vec++;
            if ({mem_req, busy, owner} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_ctrl cyc%0d: got req/busy/owner=%b want 000", c, {mem_req, busy, owner});
            end
            n_vec++;
            if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_oks cyc%0d: got %b want 0000", c, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
            end
        end
        mem_addr_ok = 0; mem_data_ok = 0;
        rst = 1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got mem_req=%b want 0", mem_req);
        end
        step();
        #1;
        n_vec++;
        if (owner !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL reset_first_grant: got owner=%b req=%b addr=%h want 1 1 00002000", owner, mem_req, mem_addr);
        end
    endtask

    task automatic test_single_fetch;
        int n_iaok, n_idok, n_dok, aok_cyc;
        logic [31:0] got_rdata;
        n_iaok = 0; n_idok = 0; n_dok = 0; aok_cyc = -1; got_rdata = 0;
        do_reset();
        inst_addr = 32'hBFC0_0000;
        for (int i = 0; i < 10; i++) begin
            inst_req    = (i <= 3);
            mem_addr_ok = (i == 3);
            mem_data_ok = (i == 6);
            mem_rdata   = (i == 6) ? 32'h3C08_0001 : 32'h0;
            #1;
            if (inst_addr_ok) begin n_iaok++; aok_cyc = i; end
            if (inst_data_ok) begin n_idok++; got_rdata = inst_rdata; end
            if (data_addr_ok || data_data_ok) n_dok++;
            if (i == 0) begin
                n_vec++;
                if (mem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL fetch_arb_cycle: got mem_req=%b want 0", mem_req);
                end
            end
            if (i == 1) begin
                n_vec++;
                if (mem_req !== 1'b1 || owner !== 1'b0 || mem_addr !== 32'hBFC0_0000) begin
                    n_err++;
                    $display("FAIL fetch_req: got req=%b owner=%b addr=%h want 1 0 bfc00000", mem_req, owner, mem_addr);
                end
            end
            step();
        end
        n_vec++;
        if (n_iaok != 1 || aok_cyc != 3) begin
            n_err++;
            $display("FAIL fetch_addr_ok: got %0d pulses at cyc %0d want 1 at cyc 3", n_iaok, aok_cyc);
        end
        n_vec++;
        if (n_idok != 1) begin
            n_err++;
            $display("FAIL fetch_data_ok: got %0d pulses want 1", n_idok);
        end
        n_vec++;
        if (got_rdata !== 32'h3C08_0001) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h want 3c080001", got_rdata);
        end
        n_vec++;
        if (n_dok != 0) begin
            n_err++;
            $display("FAIL fetch_data_side_quiet: got %0d data oks want 0", n_dok);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_end_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_contention;
        logic exp_own [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_addr;
        do_reset();
        inst_req = 1; data_req = 1;
        inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
        mem_addr_ok = 1; mem_data_ok = 1;
        step();
        for (int g = 0; g < 10; g++) begin
            #1;
            exp_addr = exp_own[g] ? 32'h0000_2000 : 32'h0000_1000;
            n_vec++;
            if (owner !== exp_own[g] || mem_addr !== exp_addr || mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL contention_grant%0d: got owner=%b addr=%h req=%b want %b %h 1", g, owner, mem_addr, mem_req, exp_own[g], exp_addr);
            end
            n_vec++;
            if (data_addr_ok !== exp_own[g] || inst_addr_ok !== !exp_own[g]) begin
                n_err++;
                $display("FAIL contention_aok%0d: got d/i=%b%b want %b%b", g, data_addr_ok, inst_addr_ok, exp_own[g], !exp_own[g]);
            end
            step(); step(); step();
        end
        clear_inputs();
    endtask

    task automatic test_cancel;
        do_reset();
        data_req = 1; data_addr = 32'h0000_3000; inst_addr = 32'h0000_4000;
        step();
        #1;
        n_vec++;
        if (owner !== 1'b1 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL cancel_grant: got owner=%b req=%b want 1 1", owner, mem_req);
        end
        data_req = 0; inst_req = 1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_drop: got req=%b daok=%b want 0 0", mem_req, data_addr_ok);
        end
        step();
        mem_data_ok = 1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || data_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_idle: got busy=%b req=%b ddok=%b want 0 0 0", busy, mem_req, data_data_ok);
        end
        mem_data_ok = 0;
        step();
        #1;
        n_vec++;
        if (owner !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_4000) begin
            n_err++;
            $display("FAIL cancel_inst_grant: got owner=%b req=%b addr=%h want 0 1 00004000", owner, mem_req, mem_addr);
        end
        clear_inputs();
    endtask

    task automatic test_write;
        do_reset();
        data_req = 1; data_wr = 1; data_wen = 4'b0011; data_size = 2'b01;
        data_addr = 32'h8000_1002; data_wdata = 32'h0000_BEEF;
        inst_wr = 0; inst_wen = 4'b1100; inst_size = 2'b10;
        inst_addr = 32'h1111_1110; inst_wdata = 32'h2222_2222;
        step();
        #1;
        n_vec++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wen !== 4'b0011 || mem_size !== 2'b01) begin
            n_err++;
            $display("FAIL write_ctrl: got req=%b wr=%b wen=%b size=%b want 1 1 0011 01", mem_req, mem_wr, mem_wen, mem_size);
        end
        n_vec++;
        if (mem_addr !== 32'h8000_1002 || mem_wdata !== 32'h0000_BEEF) begin
            n_err++;
            $display("FAIL write_addr_data: got %h %h want 80001002 0000beef", mem_addr, mem_wdata);
        end
        mem_addr_ok = 1;
        #1;
        n_vec++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            n_err++;
            $display("FAIL write_aok: got d/i=%b%b want 10", data_addr_ok, inst_addr_ok);
        end
        step();
        mem_addr_ok = 0; data_req = 0;
        mem_data_ok = 1; mem_rdata = 32'h0000_1234;
        #1;
        n_vec++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h0000_1234 || inst_rdata !== 32'h0 || inst_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL write_dok: got ddok=%b drd=%h ird=%h idok=%b want 1 00001234 0 0", data_data_ok, data_rdata, inst_rdata, inst_data_ok);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        data_req = 1; data_addr = 32'h0000_5000;
        step();
        mem_addr_ok = 1;
        step();
        mem_addr_ok = 0; data_req = 0;
        #1;
        n_vec++;
        if (busy !== 1'b1 || owner !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_in_data: got busy=%b owner=%b want 1 1", busy, owner);
        end
        rst = 0; mem_data_ok = 1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || owner !== 1'b0 || data_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_forced: got busy=%b owner=%b ddok=%b want 0 0 0", busy, owner, data_data_ok);
        end
        mem_data_ok = 0;
        step();
        rst = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (busy !== 1'b0 || data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_late_dok: got busy=%b ddok=%b idok=%b want 0 0 0", busy, data_data_ok, inst_data_ok);
        end
        step();
        #1;
        n_vec++;
        if (busy !== 1'b0 || data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_stay_idle: got busy=%b ddok=%b idok=%b want 0 0 0", busy, data_data_ok, inst_data_ok);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_cancel();
        test_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
